// File: rtl/display_arbiter.sv
// display_arbiter: fixed-priority owner selection for a shared 7-segment
// driver, with a minimum on-screen hold window and per-owner blink gating.
module display_arbiter #(
   parameter int DIGITS       = 5,
   parameter int SOURCES      = 3,
   parameter int HOLD_CYCLES  = 50_000_000,
   parameter int BLINK_CYCLES = 25_000_000
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [SOURCES-1:0]          req,
   input  logic [SOURCES-1:0]          blink,
   input  logic [SOURCES*DIGITS*4-1:0] src_digits,
   input  logic [SOURCES*DIGITS-1:0]   src_digit_enable,
   input  logic [SOURCES*DIGITS-1:0]   src_dp_enable,
   output logic [SOURCES-1:0]          grant,
   output logic [DIGITS*4-1:0]         digits,
   output logic [DIGITS-1:0]           digit_enable,
   output logic [DIGITS-1:0]           dp_enable,
   output logic                        holding
);

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
   localparam logic [SOURCES-1:0] ONE = SOURCES'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HOLD,
      S_OWN
   } state_e;

   state_e                state_q, state_d;
   logic [SOURCES-1:0]    grant_q, grant_d;
   logic [HW-1:0]         hold_q, hold_d;
   logic [BW-1:0]         bcnt_q, bcnt_d;
   logic                  phase_q, phase_d;
   logic [DIGITS*4-1:0]   digits_q, digits_d;
   logic [DIGITS-1:0]     den_q, den_d;
   logic [DIGITS-1:0]     dp_q, dp_d;
   logic                  holding_q, holding_d;

   logic [SOURCES-1:0]    higher;
   logic [SOURCES-1:0]    others;
   logic                  owner_rq;
   logic [DIGITS*4-1:0]   sel_digits;
   logic [DIGITS-1:0]     sel_en;
   logic [DIGITS-1:0]     sel_dp;
   logic                  sel_blink;

   // Isolates the lowest set bit, i.e. the highest-priority requester.
   function automatic logic [SOURCES-1:0] pick_f(
      input logic [SOURCES-1:0] v
   );
      return v & (~v + ONE);
   endfunction

   always_comb begin
      higher   = req & (grant_q - ONE);
      others   = req & ~grant_q;
      owner_rq = |(req & grant_q);
      state_d  = state_q;
      grant_d  = grant_q;
      hold_d   = hold_q;
      unique case (state_q)
         S_IDLE: begin
            if (|req) begin
               state_d = S_HOLD;
               grant_d = pick_f(req);
               hold_d  = HOLD_LOAD;
            end
         end
         S_HOLD: begin
            if (hold_q != '0) begin
               hold_d = hold_q - HW'(1);
            end else if (|higher) begin
               grant_d = pick_f(higher);
               hold_d  = HOLD_LOAD;
            end else if (owner_rq) begin
               state_d = S_OWN;
            end else if (|others) begin
               grant_d = pick_f(others);
               hold_d  = HOLD_LOAD;
            end else begin
               state_d = S_IDLE;
               grant_d = '0;
            end
         end
         S_OWN: begin
            if (|higher) begin
               state_d = S_HOLD;
               grant_d = pick_f(higher);
               hold_d  = HOLD_LOAD;
            end else if (!owner_rq) begin
               if (|others) begin
                  state_d = S_HOLD;
                  grant_d = pick_f(others);
                  hold_d  = HOLD_LOAD;
               end else begin
                  state_d = S_IDLE;
                  grant_d = '0;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
         end
      endcase
   end

   // Slice mux keyed on the next-state grant; all-zero grant yields zeros.
   always_comb begin
      sel_digits = '0;
      sel_en     = '0;
      sel_dp     = '0;
      sel_blink  = 1'b0;
      for (int s = 0; s < SOURCES; s++) begin
         if (grant_d[s]) begin
            sel_digits |= src_digits[s*DIGITS*4 +: DIGITS*4];
            sel_en     |= src_digit_enable[s*DIGITS +: DIGITS];
            sel_dp     |= src_dp_enable[s*DIGITS +: DIGITS];
            sel_blink  |= blink[s];
         end
      end
   end

   always_comb begin
      bcnt_d  = bcnt_q;
      phase_d = phase_q;
      if (grant_d != grant_q) begin
         bcnt_d  = '0;
         phase_d = 1'b1;
      end else if (bcnt_q == BLINK_LAST) begin
         bcnt_d  = '0;
         phase_d = ~phase_q;
      end else begin
         bcnt_d = bcnt_q + BW'(1);
      end
      digits_d  = sel_digits;
      dp_d      = sel_dp;
      den_d     = sel_en & {DIGITS{phase_d | ~sel_blink}};
      holding_d = (state_d == S_HOLD);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         grant_q   <= '0;
         hold_q    <= '0;
         bcnt_q    <= '0;
         phase_q   <= 1'b1;
         digits_q  <= '0;
         den_q     <= '0;
         dp_q      <= '0;
         holding_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         hold_q    <= hold_d;
         bcnt_q    <= bcnt_d;
         phase_q   <= phase_d;
         digits_q  <= digits_d;
         den_q     <= den_d;
         dp_q      <= dp_d;
         holding_q <= holding_d;
      end
   end

   assign grant        = grant_q;
   assign digits       = digits_q;
   assign digit_enable = den_q;
   assign dp_enable    = dp_q;
   assign holding      = holding_q;

endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter: vector table, directed corner sequences and a
// randomized run against an owner/hold/blink reference model.
module tb_display_arbiter;

   localparam int S  = 3;
   localparam int D  = 2;
   localparam int HC = 4;
   localparam int BC = 3;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [S-1:0]      req;
   logic [S-1:0]      blink;
   logic [S*D*4-1:0]  src_digits;
   logic [S*D-1:0]    src_digit_enable;
   logic [S*D-1:0]    src_dp_enable;
   logic [S-1:0]      grant;
   logic [D*4-1:0]    digits;
   logic [D-1:0]      digit_enable;
   logic [D-1:0]      dp_enable;
   logic              holding;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   display_arbiter #(
      .DIGITS(D),
      .SOURCES(S),
      .HOLD_CYCLES(HC),
      .BLINK_CYCLES(BC)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .req(req),
      .blink(blink),
      .src_digits(src_digits),
      .src_digit_enable(src_digit_enable),
      .src_dp_enable(src_dp_enable),
      .grant(grant),
      .digits(digits),
      .digit_enable(digit_enable),
      .dp_enable(dp_enable),
      .holding(holding)
   );

   // Reference model: owner index, remaining hold count, blink phase.
   int          m_own;
   int          m_hold;
   bit          m_in_hold;
   int          m_bcnt;
   bit          m_phase;
   logic [15:0] e_all;

   task automatic model_reset();
      m_own     = -1;
      m_hold    = 0;
      m_in_hold = 0;
      m_bcnt    = 0;
      m_phase   = 1;
      e_all     = '0;
   endtask

   task automatic model_step();
      int          lowest;
      int          nxt;
      logic [2:0]  g;
      logic [7:0]  dg;
      logic [1:0]  en;
      logic [1:0]  dp;
      lowest = -1;
      for (int i = S - 1; i >= 0; i--)
         if (req[i]) lowest = i;
      nxt = m_own;
      if (m_in_hold && m_hold > 0) begin
         m_hold--;
      end else if (lowest != m_own) begin
         nxt       = lowest;
         m_in_hold = (lowest >= 0);
         m_hold    = HC - 1;
      end else begin
         m_in_hold = 0;
      end
      if (nxt != m_own) begin
         m_bcnt  = 0;
         m_phase = 1;
      end else if (m_bcnt == BC - 1) begin
         m_bcnt  = 0;
         m_phase = !m_phase;
      end else begin
         m_bcnt++;
      end
      m_own = nxt;
      g  = '0;
      dg = '0;
      en = '0;
      dp = '0;
      if (m_own >= 0) begin
         g[m_own] = 1'b1;
         dg = src_digits[m_own*D*4 +: D*4];
         dp = src_dp_enable[m_own*D +: D];
         if (m_phase || !blink[m_own])
            en = src_digit_enable[m_own*D +: D];
      end
      e_all = {g, m_in_hold, dg, en, dp};
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic reset_task();
      reset_n = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   function automatic logic [15:0] mk(input logic [2:0] g, input logic h,
                                      input logic [7:0] d,
                                      input logic [1:0] e,
                                      input logic [1:0] p);
      return {g, h, d, e, p};
   endfunction

   typedef struct {
      logic [2:0]  r;
      logic [15:0] exp;
   } vec_t;

   vec_t vq[$];

   function automatic logic [15:0] outs();
      return {grant, holding, digits, digit_enable, dp_enable};
   endfunction

   initial begin
      logic [15:0] g0, g0o, g1, g2;
      bit          on_pat[10];
      bit          hold_pat[5];

      g2  = mk(3'b100, 1'b1, 8'h56, 2'b10, 2'b11);
      g0  = mk(3'b001, 1'b1, 8'h12, 2'b11, 2'b01);
      g0o = mk(3'b001, 1'b0, 8'h12, 2'b11, 2'b01);
      g1  = mk(3'b010, 1'b1, 8'h34, 2'b01, 2'b10);
      vq.push_back('{3'b100, g2});
      for (int i = 0; i < 3; i++) vq.push_back('{3'b001, g2});
      vq.push_back('{3'b001, g0});
      for (int i = 0; i < 3; i++) vq.push_back('{3'b000, g0});
      vq.push_back('{3'b000, 16'h0});
      for (int i = 0; i < 4; i++) vq.push_back('{3'b010, g1});
      for (int i = 0; i < 4; i++) vq.push_back('{3'b011, g0});
      vq.push_back('{3'b011, g0o});
      vq.push_back('{3'b110, g1});

      // Reset with all requests up, then first grant and src latency
      reset_n          = 1'b0;
      model_reset();
      req              = 3'b111;
      blink            = '0;
      src_digits       = 24'h563412;
      src_digit_enable = 6'b100111;
      src_dp_enable    = 6'b111001;
      #12;
      check("reset_outs", 32'(outs()), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      check("first_grant", 32'(grant), 32'b001);
      check("first_holding", 32'(holding), 32'h1);
      src_digits[7:0] = 8'hA5;
      tick();
      check("src_latency", 32'(digits), 32'hA5);
      src_digits = 24'h563412;

      // Table: hold blocks preemption, owner drop, idle, own, release
      req = '0;
      reset_task();
      foreach (vq[i]) begin
         req = vq[i].r;
         tick();
         check($sformatf("vec%0d", i), 32'(outs()), 32'(vq[i].exp));
      end

      // OWN is not preempted by lower-priority requests
      req = 3'b111;
      reset_task();
      for (int i = 0; i < 5; i++) tick();
      for (int i = 0; i < 20; i++) begin
         tick();
         check("own_keep", 32'({grant, holding}), 32'({3'b001, 1'b0}));
      end
      req = 3'b110;
      tick();
      check("own_release", 32'({grant, holding}), 32'({3'b010, 1'b1}));

      // Blink pattern from the grant edge, then live blink release
      req = '0;
      reset_task();
      src_digit_enable = 6'b001111;
      blink            = 3'b010;
      req              = 3'b010;
      on_pat = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0};
      for (int i = 0; i < 10; i++) begin
         tick();
         check($sformatf("blink%0d", i), 32'(digit_enable),
               on_pat[i] ? 32'b11 : 32'b00);
      end
      blink = '0;
      tick();
      check("blink_off", 32'(digit_enable), 32'b11);
      src_digit_enable = 6'b100111;

      // Asynchronous reset in the middle of a hold window
      req = '0;
      reset_task();
      req = 3'b100;
      tick();
      tick();
      @(negedge clk);
      reset_n = 1'b0;
      model_reset();
      #1;
      check("async_reset", 32'(outs()), 32'h0);
      #1;
      reset_n = 1'b1;
      hold_pat = '{1, 1, 1, 1, 0};
      for (int i = 0; i < 5; i++) begin
         tick();
         check($sformatf("rehold%0d", i), 32'({grant, holding}),
               32'({3'b100, hold_pat[i]}));
      end

      // Randomized run against the reference model
      req = '0;
      reset_task();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) req = S'($urandom);
         if ($urandom_range(0, 7) == 0) blink = S'($urandom);
         src_digits       = 24'($urandom);
         src_digit_enable = 6'($urandom);
         src_dp_enable    = 6'($urandom);
         if (i == 1500) reset_task();
         tick();
         check("rand_outs", 32'(outs()), 32'(e_all));
         check("rand_onehot", 32'($onehot0(grant)), 32'h1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/display_arbiter.md
Name: display_arbiter

Overview:
- Shares one multiplexed 7-segment display driver between SOURCES independent content producers, e.g. running time, lap time and status messages.
- Arbitration is fixed-priority with a guaranteed minimum on-screen hold time.
- Per-source blink is supported.
- Sits between the stopwatch logic and the display driver. Its digits, digit_enable and dp_enable outputs connect directly to the driver's identically named inputs.

Parameters:
- DIGITS, 5, digits per source frame (must match display driver)
- SOURCES, 3, number of requesters; index 0 = highest priority
- HOLD_CYCLES, 50_000_000, minimum clk cycles a newly granted source stays displayed (>=1)
- BLINK_CYCLES, 25_000_000, clk cycles per blink half-period (>=1)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req  in  SOURCES  per-source display request, level-sensitive
- blink  in  SOURCES  per-source blink request, honoured only while that source is granted
- src_digits  in  SOURCES*DIGITS*4  source s occupies bits [(s+1)*DIGITS*4-1 : s*DIGITS*4]
- src_digit_enable  in  SOURCES*DIGITS  source s occupies bits [(s+1)*DIGITS-1 : s*DIGITS]
- src_dp_enable  in  SOURCES*DIGITS  same packing as src_digit_enable
- grant  out  SOURCES  one-hot current owner, or all-zero when idle
- digits  out  DIGITS*4  registered frame of the owner
- digit_enable  out  DIGITS  registered digit enables of the owner, gated by blink
- dp_enable  out  DIGITS  registered decimal points of the owner
- holding  out  1  high while the owner is inside its minimum hold window

Behaviour:
- Clock and reset: single clock, clk. reset_n is asynchronous and active-low; on assertion, all state clears immediately.
- Reset values:
  - state = IDLE
  - grant, digits, digit_enable, dp_enable = 0
  - holding = 0
  - hold counter = 0
  - blink counter = 0, blink phase = on
- States:
  - IDLE: no owner.
  - HOLD: owner granted; hold counter running.
  - OWN: hold satisfied; owner keeps the display until it releases or is preempted.
- Selection function: "pick" = lowest-index asserted req bit.
- IDLE:
  - If any req, the next edge sets grant to pick, loads the hold counter with HOLD_CYCLES-1 and enters HOLD.
  - Otherwise stay in IDLE.
- HOLD:
  - The counter decrements each cycle. req changes, including the owner's, are ignored while the counter is nonzero.
  - At counter = 0 the next edge re-evaluates:
    - higher-priority req present -> grant it, reload counter, stay in HOLD;
    - else owner req high -> OWN;
    - else other req present -> grant pick, reload counter, stay in HOLD;
    - else -> IDLE with grant = 0.
  - Result: every grant lasts at least HOLD_CYCLES cycles. With HOLD_CYCLES = 1, HOLD lasts exactly one cycle.
- OWN, evaluated every cycle:
  - higher-priority req -> switch to it and enter HOLD;
  - else owner req low -> pick among the remaining reqs (HOLD), or IDLE if there are none;
  - lower-priority reqs never preempt.
- Switching: switches are gapless. grant changes directly from old to new owner in one edge, never passing through zero.
- holding is high exactly while state = HOLD.
- Datapath registers:
  - Every edge, digits and dp_enable load the slice of the owner selected by the next-state grant. src_* changes therefore appear with 1-cycle latency.
  - The outputs update on the same edge as grant.
  - When the next state is IDLE, all three outputs load 0.
- Blink:
  - The counter counts 0..BLINK_CYCLES-1; the phase toggles on wrap.
  - Counter and phase reset to 0 and on at every grant change, so a new owner is always shown first.
  - Registered digit_enable = owner enable AND (phase on OR blink[owner] = 0).
  - blink is sampled live: deasserting it restores the enables on the next edge.
- Invariants: grant is always one-hot or zero; undefined src bits never propagate while grant = 0.

Test Plan:
Bench parameters: SOURCES=3, DIGITS=2, HOLD_CYCLES=4, BLINK_CYCLES=3.
1. Reset: reset_n low with req=3'b111 -> all outputs 0. After release, next edge gives grant=3'b001 and holding=1. digits equals src0 frame one cycle after src0 changes.
2. Hold blocks preemption: source 2 granted at edge t; req0 rises at t+1 -> grant stays 3'b100 through t+3, becomes 3'b001 at edge t+4. No cycle has grant=0.
3. Owner drops during hold: source 1 granted, req1 pulsed one cycle, no other reqs -> grant 3'b010 for exactly 4 cycles, then IDLE with grant=0 and digits=0, digit_enable=0.
4. OWN without preemption: source 0 in OWN; req1 and req2 held high 20 cycles -> grant stays 3'b001. req0 drops -> next edge grant=3'b010 and holding=1.
5. Blink: source 1 owned, src1 digit_enable=2'b11, blink[1]=1 -> digit_enable sequence 11,11,11,00,00,00,11 repeating from the grant edge. blink[1]=0 -> 2'b11 on next edge.
6. Reset mid-HOLD: assert reset_n low asynchronously -> grant, digits, digit_enable, holding = 0 before the next clk edge. On release the fresh arbitration restarts the hold count at 4.
